exec_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the fetch/decode/execute/memory pipeline, wrapped around the execute stage.
- Detects load-use hazards and execute-stage redirects (taken branch/jump), plus memory back-pressure.
- Generates stall, bubble, flush and PC-redirect controls for the stage registers around execute.
- Holds the redirect target in a registered window so fetch sees a clean, glitch-free redirect.

---
 rtl/exec_hazard_ctrl_if.sv | 46 ++++
 rtl/exec_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_exec_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/exec_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stage registers and exec_hazard_ctrl.
// master = pipeline side (drives hazard inputs), slave = controller side.
interface exec_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd_addr;
    logic             ex_w_enable;
    logic             ex_is_load;
    logic             ex_redirect;
    logic [31:0]      ex_redirect_pc;
    logic             mem_busy;

    logic             pc_stall;
    logic             fd_stall;
    logic             de_bubble;
    logic             fd_flush;
    logic             de_flush;
    logic             em_hold;
    logic             pc_redirect_valid;
    logic [31:0]      pc_redirect_pc;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        output ex_rd_addr, ex_w_enable, ex_is_load, ex_redirect, ex_redirect_pc,
        output mem_busy,
        input  pc_stall, fd_stall, de_bubble, fd_flush, de_flush, em_hold,
        input  pc_redirect_valid, pc_redirect_pc, ctrl_state,
        input  perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
        input  ex_rd_addr, ex_w_enable, ex_is_load, ex_redirect, ex_redirect_pc,
        input  mem_busy,
        output pc_stall, fd_stall, de_bubble, fd_flush, de_flush, em_hold,
        output pc_redirect_valid, pc_redirect_pc, ctrl_state,
        output perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Purpose: stall/bubble/flush/redirect sequencing around execute; perf counters under EXEC_HAZARD_PERF_EN.
// Latency: stall/flush controls 0 cycles (combinational); redirect PC valid 1 cycle after ex_redirect.
// Backpressure: mem_busy freezes the whole pipe (pc/fd stall + em_hold) and pauses the redirect window.
module exec_hazard_ctrl #(
    parameter int NUM_FLUSH_CYC = 2,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic rstd,
    exec_hazard_ctrl_if.slave hz_if
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        REDIRECT = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_flush_cnt;
    logic [3:0]  w_flush_cnt_nxt;
    logic [31:0] r_redirect_pc;
    logic        w_load_pc;
    logic        w_lu;
    logic        w_pc_stall;
    logic        w_fd_stall;
    logic        w_de_bubble;
    logic        w_fd_flush;
    logic        w_de_flush;
    logic        w_em_hold;
    logic        w_redirect_vld;

    always_comb begin
        w_lu = hz_if.ex_is_load && hz_if.ex_w_enable && (hz_if.ex_rd_addr != 5'd0) &&
               ((hz_if.id_use_rs1 && (hz_if.id_rs1_addr == hz_if.ex_rd_addr)) ||
                (hz_if.id_use_rs2 && (hz_if.id_rs2_addr == hz_if.ex_rd_addr)));
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_load_pc       = 1'b0;
        w_pc_stall      = 1'b0;
        w_fd_stall      = 1'b0;
        w_de_bubble     = 1'b0;
        w_fd_flush      = 1'b0;
        w_de_flush      = 1'b0;
        w_em_hold       = 1'b0;
        w_redirect_vld  = 1'b0;
        case (r_state)
            RUN: begin
                if (hz_if.mem_busy) begin
                    w_pc_stall  = 1'b1;
                    w_fd_stall  = 1'b1;
                    w_em_hold   = 1'b1;
                    w_state_nxt = MEM_WAIT;
                end else if (hz_if.ex_redirect) begin
                    w_fd_flush      = 1'b1;
                    w_de_flush      = 1'b1;
                    w_load_pc       = 1'b1;
                    w_flush_cnt_nxt = 4'(NUM_FLUSH_CYC);
                    w_state_nxt     = REDIRECT;
                end else if (w_lu) begin
                    w_pc_stall  = 1'b1;
                    w_fd_stall  = 1'b1;
                    w_de_bubble = 1'b1;
                    w_state_nxt = LU_STALL;
                end
            end
            LU_STALL: begin
                // Bubble sits in execute, so neither load-use nor redirect can be live here.
                if (hz_if.mem_busy) begin
                    w_pc_stall  = 1'b1;
                    w_fd_stall  = 1'b1;
                    w_em_hold   = 1'b1;
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            REDIRECT: begin
                w_redirect_vld = 1'b1;
                w_fd_flush     = 1'b1;
                if (hz_if.mem_busy) begin
                    w_em_hold = 1'b1;
                end else if (r_flush_cnt <= 4'd1) begin
                    w_state_nxt = RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            MEM_WAIT: begin
                if (hz_if.mem_busy) begin
                    w_pc_stall = 1'b1;
                    w_fd_stall = 1'b1;
                    w_em_hold  = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_state       <= RUN;
            r_flush_cnt   <= 4'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (w_load_pc) begin
                r_redirect_pc <= hz_if.ex_redirect_pc;
            end
        end
    end

    // Combinational controls are masked so nothing leaks out while reset is held.
    assign hz_if.pc_stall          = w_pc_stall     & ~rstd;
    assign hz_if.fd_stall          = w_fd_stall     & ~rstd;
    assign hz_if.de_bubble         = w_de_bubble    & ~rstd;
    assign hz_if.fd_flush          = w_fd_flush     & ~rstd;
    assign hz_if.de_flush          = w_de_flush     & ~rstd;
    assign hz_if.em_hold           = w_em_hold      & ~rstd;
    assign hz_if.pc_redirect_valid = w_redirect_vld & ~rstd;
    assign hz_if.pc_redirect_pc    = r_redirect_pc;
    assign hz_if.ctrl_state        = r_state;

`ifdef EXEC_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_perf_stall_cnt;
    logic [CNT_W-1:0] r_perf_flush_cnt;

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_pc_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 1'b1;
            end
            if ((r_state == RUN) && (w_state_nxt == REDIRECT)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
            end
        end
    end

    assign hz_if.perf_stall_cnt = r_perf_stall_cnt;
    assign hz_if.perf_flush_cnt = r_perf_flush_cnt;
`else
    assign hz_if.perf_stall_cnt = {CNT_W{1'b0}};
    assign hz_if.perf_flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl: expected control vectors are queued at drive time and popped at sample time.
module tb_exec_hazard_ctrl;
    logic clk = 1'b0;
    logic rstd;
    always #5 clk = ~clk;

    exec_hazard_ctrl_if #(.CNT_W(32)) hz();

    exec_hazard_ctrl #(.NUM_FLUSH_CYC(2), .CNT_W(32)) dut (
        .clk   (clk),
        .rstd  (rstd),
        .hz_if (hz)
    );

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] pc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [8:0] obs_ctl;
    assign obs_ctl = {hz.pc_stall, hz.fd_stall, hz.de_bubble, hz.fd_flush, hz.de_flush,
                      hz.em_hold, hz.pc_redirect_valid, hz.ctrl_state};

    function automatic logic [8:0] mk(input logic ps, input logic fs, input logic db,
                                      input logic ff, input logic df, input logic eh,
                                      input logic v, input logic [1:0] st);
        return {ps, fs, db, ff, df, eh, v, st};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [8:0] ctl, input logic [31:0] pc, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.pc  = pc;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=%h exp=<entry>", obs_ctl);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_ctl"}, 64'(obs_ctl), 64'(e.ctl));
            chk({e.tag, "_pc"}, 64'(hz.pc_redirect_pc), 64'(e.pc));
        end
    endtask

    task automatic cyc(input logic [8:0] ctl, input logic [31:0] pc, input string tag);
        push(ctl, pc, tag);
        #3;
        sample();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        hz.id_rs1_addr    = 5'd0;
        hz.id_rs2_addr    = 5'd0;
        hz.id_use_rs1     = 1'b0;
        hz.id_use_rs2     = 1'b0;
        hz.ex_rd_addr     = 5'd0;
        hz.ex_w_enable    = 1'b0;
        hz.ex_is_load     = 1'b0;
        hz.ex_redirect    = 1'b0;
        hz.ex_redirect_pc = 32'd0;
        hz.mem_busy       = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        hz.id_rs1_addr = rs1;
        hz.id_use_rs1  = u1;
        hz.id_rs2_addr = rs2;
        hz.id_use_rs2  = u2;
        hz.ex_rd_addr  = rd;
        hz.ex_w_enable = we;
        hz.ex_is_load  = ld;
    endtask

    localparam logic [8:0] IDLE      = 9'b000000000;
    localparam logic [8:0] LU_HIT    = 9'b111000000;
    localparam logic [8:0] LU_ST     = 9'b000000001;
    localparam logic [8:0] RD_ISSUE  = 9'b000110000;
    localparam logic [8:0] RD_WIN    = 9'b000100110;
    localparam logic [8:0] RD_WIN_BZ = 9'b000101110;
    localparam logic [8:0] FRZ_RUN   = 9'b110001000;
    localparam logic [8:0] FRZ_WAIT  = 9'b110001011;
    localparam logic [8:0] WAIT_REL  = 9'b000000011;

    initial begin
        rstd = 1'b1;
        clr_in();
        hz.mem_busy    = 1'b1;
        hz.ex_redirect = 1'b1;
        #2;
        chk("rst_ctl_masked", 64'(obs_ctl), 64'(mk(0, 0, 0, 0, 0, 0, 0, 2'd0)));
        chk("rst_pc", 64'(hz.pc_redirect_pc), 64'd0);
        tick();
        clr_in();
        rstd = 1'b0;

        // Load-use hazards
        tick(); cyc(IDLE, 32'd0, "idle");
        tick(); set_lu(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1); cyc(LU_HIT, 32'd0, "lu_rs2");
        tick(); cyc(LU_ST, 32'd0, "lu_stall_st");
        tick(); clr_in(); cyc(IDLE, 32'd0, "lu_back_run");
        tick(); set_lu(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1); cyc(IDLE, 32'd0, "lu_rd0");
        tick(); set_lu(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1); cyc(IDLE, 32'd0, "lu_nouse");
        tick(); set_lu(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); cyc(LU_HIT, 32'd0, "lu_rs1");
        tick(); clr_in(); cyc(LU_ST, 32'd0, "lu_rs1_st");

        // Plain redirect, two-cycle window
        tick(); hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 32'h0000_0080;
        cyc(RD_ISSUE, 32'd0, "redir_issue");
        tick(); hz.ex_redirect = 1'b0; cyc(RD_WIN, 32'h80, "redir_w0");
        tick(); cyc(RD_WIN, 32'h80, "redir_w1");
        tick(); cyc(IDLE, 32'h80, "redir_done");

        // Freeze with redirect and load-use both pending
        tick(); hz.mem_busy = 1'b1; hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 32'h0000_0100;
        set_lu(5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
        cyc(FRZ_RUN, 32'h80, "frz0");
        tick(); cyc(FRZ_WAIT, 32'h80, "frz1");
        tick(); cyc(FRZ_WAIT, 32'h80, "frz2");
        tick(); hz.mem_busy = 1'b0; cyc(WAIT_REL, 32'h80, "frz_rel");
        tick(); cyc(RD_ISSUE, 32'h80, "frz_redir");

        // Busy pulses inside the redirect window pause the countdown
        tick(); clr_in(); hz.mem_busy = 1'b1; cyc(RD_WIN_BZ, 32'h100, "rb_busy0");
        tick(); hz.mem_busy = 1'b0; hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 32'h0000_0200;
        cyc(RD_WIN, 32'h100, "rb_run0");
        tick(); hz.ex_redirect = 1'b0; hz.mem_busy = 1'b1; cyc(RD_WIN_BZ, 32'h100, "rb_busy1");
        tick(); hz.mem_busy = 1'b0; cyc(RD_WIN, 32'h100, "rb_run1");
        tick(); cyc(IDLE, 32'h100, "rb_done");

`ifdef EXEC_HAZARD_PERF_EN
        chk("perf_stall", 64'(hz.perf_stall_cnt), 64'd5);
        chk("perf_flush", 64'(hz.perf_flush_cnt), 64'd2);
`else
        chk("perf_stall_off", 64'(hz.perf_stall_cnt), 64'd0);
        chk("perf_flush_off", 64'(hz.perf_flush_cnt), 64'd0);
`endif

        // Reset in the middle of a redirect window
        tick(); hz.ex_redirect = 1'b1; hz.ex_redirect_pc = 32'h0000_0044;
        cyc(RD_ISSUE, 32'h100, "r2_issue");
        tick(); hz.ex_redirect = 1'b0; cyc(RD_WIN, 32'h44, "r2_w0");
        #1;
        rstd = 1'b1;
        hz.mem_busy = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'(obs_ctl), 64'(mk(0, 0, 0, 0, 0, 0, 0, 2'd0)));
        chk("rst_mid_perf_stall", 64'(hz.perf_stall_cnt), 64'd0);
        chk("rst_mid_perf_flush", 64'(hz.perf_flush_cnt), 64'd0);
        tick(); rstd = 1'b0; hz.mem_busy = 1'b0;
        cyc(IDLE, 32'd0, "post_rst");
        tick(); cyc(IDLE, 32'd0, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
